// File: rtl/muldiv_if.sv
// Handshake bundle between the execute stage and the HI/LO mul/div unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.
// Shift-add multiply, restoring divide, one step per cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               bzero_q, bzero_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               done_q, done_d;

  logic               sgn_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  always_comb begin
    sgn_op = ~bus.op[0];
    a_neg  = sgn_op & bus.a[WIDTH-1];
    b_neg  = sgn_op & bus.b[WIDTH-1];
    a_mag  = a_neg ? -bus.a : bus.a;
    b_mag  = b_neg ? -bus.b : bus.b;
  end

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   div_quo;

  // acc holds {upper, multiplier} for mul and {remainder, quotient} for div
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, opnd_q};
    div_diff = div_sh[WIDTH-1:0] - opnd_q;
    div_rem  = div_ge ? div_diff : div_sh[WIDTH-1:0];
    div_quo  = {acc_q[WIDTH-2:0], div_ge};
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0]
                         : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH]
                         : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    opnd_d    = opnd_q;
    araw_d    = araw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          is_div_d  = bus.op[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          bzero_d   = (bus.b == '0);
          araw_d    = bus.a;
          if (bus.op[1]) begin
            opnd_d = b_mag;
            acc_d  = {{WIDTH{1'b0}}, a_mag};
          end else begin
            opnd_d = a_mag;
            acc_d  = {{WIDTH{1'b0}}, b_mag};
          end
        end else begin
          if (bus.mthi) hi_d = bus.a;
          if (bus.mtlo) lo_d = bus.a;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        acc_d = is_div_q ? {div_rem, div_quo}
                         : {mul_sum, acc_q[WIDTH-1:1]};
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (bzero_q) begin
          hi_d = araw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      opnd_q    <= '0;
      araw_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      opnd_q    <= opnd_d;
      araw_q    <= araw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed vectors, corner sequences and a random sweep for muldiv_sequencer.
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = '0;
    case (op)
      2'd0: res = sa * sb;
      2'd1: res = ua * ub;
      default: begin
        if (b == 32'b0) begin
          res = {a, 32'hFFFFFFFF};
        end else if (op == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          res = {32'(ua % ub), 32'(ua / ub)};
        end
      end
    endcase
    return res;
  endfunction

  // Caller sits on a negedge; start is driven immediately.
  // mode 1: hammer start/mthi/mtlo while busy; mode 2: mtlo with start.
  task automatic run_op(input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] ehi,
                        input logic [31:0] elo,
                        input int mode,
                        input string nm);
    logic [31:0] ohi, olo;
    int n;
    bit hold, early;
    ohi = bus.hi;
    olo = bus.lo;
    n = 0;
    hold = 1'b1;
    early = 1'b0;
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    if (mode == 2) bus.mtlo = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mtlo = 1'b0;
    while (bus.busy && n < 40) begin
      n++;
      if (bus.hi !== ohi || bus.lo !== olo) hold = 1'b0;
      if (bus.done) early = 1'b1;
      if (mode == 1) begin
        bus.start = 1'b1;
        bus.op = ~op;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.mthi = 1'b1;
        bus.mtlo = 1'b1;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    chk({nm, "_busy"}, n, 33);
    chk({nm, "_hold"}, hold, 1);
    chk({nm, "_early"}, early, 0);
    chk({nm, "_done"}, bus.done, 1);
    chk({nm, "_hi"}, bus.hi, ehi);
    chk({nm, "_lo"}, bus.lo, elo);
    @(negedge clk);
    chk({nm, "_pulse"}, bus.done, 0);
  endtask

  initial begin
    logic [63:0] m;
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    bit          bad;

    vt[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vt[1]  = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vt[2]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[3]  = '{2'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    vt[4]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vt[5]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vt[6]  = '{2'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vt[7]  = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vt[8]  = '{2'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vt[9]  = '{2'd2, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
    vt[10] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vt[11] = '{2'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    vt[12] = '{2'd1, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'd0;
    bus.a = '0;
    bus.b = '0;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);

    bus.mthi = 1'b1;
    bus.a = 32'h1234;
    @(negedge clk);
    bus.mthi = 1'b0;
    chk("mthi_hi", bus.hi, 32'h1234);
    chk("mthi_lo", bus.lo, 0);
    bus.mtlo = 1'b1;
    bus.a = 32'hABCD;
    @(negedge clk);
    bus.mtlo = 1'b0;
    chk("mtlo_lo", bus.lo, 32'hABCD);
    chk("mtlo_hi", bus.hi, 32'h1234);
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    bus.a = 32'h5A5A5A5A;
    @(negedge clk);
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    chk("mtboth_hi", bus.hi, 32'h5A5A5A5A);
    chk("mtboth_lo", bus.lo, 32'h5A5A5A5A);
    @(negedge clk);

    // consecutive table entries start the cycle after the previous done
    for (int i = 0; i < 13; i++)
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, 0,
             $sformatf("v%0d", i));

    run_op(2'd1, 32'd2, 32'd3, 32'd0, 32'd6, 1, "busy_ign");
    run_op(2'd1, 32'd5, 32'd6, 32'd0, 32'd30, 2, "start_mtlo");
    run_op(2'd0, 32'hFFFFFFFB, 32'd9, 32'hFFFFFFFF, 32'hFFFFFFD3, 0, "pre_rst");

    bus.start = 1'b1;
    bus.op = 2'd3;
    bus.a = 32'd1000;
    bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_hi", bus.hi, 0);
    chk("mrst_lo", bus.lo, 0);
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy || bus.lo !== 32'd0) bad = 1'b1;
    end
    chk("mrst_quiet", bad, 0);

    for (int i = 0; i < 900; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom;
      if ($urandom_range(0, 7) == 0) ra = $urandom_range(0, 20);
      m = model(rop, ra, rb);
      run_op(rop, ra, rb, m[63:32], m[31:0], 0,
             $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
